s2_seq_ctrl: RTL

Sequencer for the s2 byte-serialising datapath (two 8-bit input registers, 2:1 byte mux, 8-bit result register). It accepts a burst of 16-bit words over a valid/ready handshake and drives `pl`, `sel` and `plr` so each word leaves the result register as two bytes, each under its own valid/ready handshake. It sits between an upstream word producer and the s2 instance and owns all s2 control inputs except `reset`.

---
 rtl/s2_ctrl_pkg.sv | 16 +
 rtl/s2_word_cnt.sv | 22 ++
 rtl/s2_seq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/s2_ctrl_pkg.sv
// Shared types and defaults for the s2 byte-serialiser sequencer.
package s2_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEL0 = 3'd2,
    S_OUT0 = 3'd3,
    S_SEL1 = 3'd4,
    S_OUT1 = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/s2_word_cnt.sv
// Word counter: cleared when a burst starts, bumped per emitted word.
module s2_word_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/s2_seq_ctrl.sv
// Sequencer driving s2 pl/sel/plr so each 16-bit word leaves
// as two handshaked bytes.
module s2_seq_ctrl #(
  parameter int CNT_W = s2_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pl,
  output logic             sel,
  output logic             plr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  import s2_ctrl_pkg::*;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] len_q;
  logic             msb_q;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             last;

  assign cnt_clr = (state == S_IDLE) && start;
  assign cnt_inc = (state == S_OUT1) && out_ready;
  // length 0 means a full wrap, which the modulo compare gives for free
  assign last    = CNT_W'(word_cnt + 1'b1) == len_q;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      len_q <= '0;
      msb_q <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr) begin
        len_q <= burst_len;
        msb_q <= msb_first;
      end
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    pl        = 1'b0;
    sel       = 1'b0;
    plr       = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        pl       = in_valid;
        if (in_valid) state_n = S_SEL0;
      end
      S_SEL0: begin
        plr     = 1'b1;
        sel     = msb_q;
        state_n = S_OUT0;
      end
      S_OUT0: begin
        out_valid = 1'b1;
        sel       = msb_q;
        if (out_ready) state_n = S_SEL1;
      end
      S_SEL1: begin
        plr     = 1'b1;
        sel     = ~msb_q;
        state_n = S_OUT1;
      end
      S_OUT1: begin
        // sel held so it only moves on entry to SEL0/SEL1
        out_valid = 1'b1;
        sel       = ~msb_q;
        if (out_ready) state_n = last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  s2_word_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (word_cnt)
  );

endmodule
